// File: rtl/layer_mem_arbiter.sv
// Round-robin arbiter sharing the layer-memory port between the conv writer (0) and pooling engine (1).
// Grant is combinational; memory strobes register one cycle later; read data returns to its issuer three cycles after the grant.
module layer_mem_arbiter #(
   parameter int AW       = 12,
   parameter int DW       = 20,
   parameter int MAX_LOCK = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic          req0_we,
   input  logic [2:0]    req0_sel,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   input  logic          req0_lock,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_data,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic          req1_we,
   input  logic [2:0]    req1_sel,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   input  logic          req1_lock,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_data,
   output logic          cwr,
   output logic          crd,
   output logic [AW-1:0] caddr_wr,
   output logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_wr,
   output logic [2:0]    csel,
   input  logic [DW-1:0] cdata_rd,
   output logic          idle
);

   localparam int CW = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

   logic          last;
   logic          lock_on;
   logic          lock_who;
   logic [CW-1:0] lock_cnt;
   logic          lock_live;
   logic          gnt0, gnt1, hs, gidx;
   logic          g_we, g_lock;
   logic [2:0]    g_sel;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;
   logic [CW-1:0] eff_cnt;
   logic          can_extend;
   logic [2:0]    tag_v;
   logic [2:0]    tag_n;

   always_comb begin
      lock_live = lock_on & (lock_who ? req1_valid : req0_valid);
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (req0_valid && !req1_valid) begin
            gnt0 = 1'b1;
         end else if (req1_valid && !req0_valid) begin
            gnt1 = 1'b1;
         end else if (req0_valid && req1_valid) begin
            if (lock_live) begin
               gnt0 = ~lock_who;
               gnt1 = lock_who;
            end else begin
               // last == 1 means requester 0 is next in line
               gnt0 = last;
               gnt1 = ~last;
            end
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign hs         = gnt0 | gnt1;
   assign gidx       = gnt1;
   assign g_we       = gidx ? req1_we    : req0_we;
   assign g_lock     = gidx ? req1_lock  : req0_lock;
   assign g_sel      = gidx ? req1_sel   : req0_sel;
   assign g_addr     = gidx ? req1_addr  : req0_addr;
   assign g_wdata    = gidx ? req1_wdata : req0_wdata;

   // A lock count only carries over when the same requester keeps the port
   assign eff_cnt    = (lock_on && (lock_who == gidx)) ? lock_cnt : '0;
   assign can_extend = g_lock && (eff_cnt < MAX_CNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last     <= 1'b1;
         lock_on  <= 1'b0;
         lock_who <= 1'b0;
         lock_cnt <= '0;
      end else if (hs) begin
         last <= gidx;
         if (can_extend) begin
            lock_on  <= 1'b1;
            lock_who <= gidx;
            lock_cnt <= eff_cnt + CW'(1);
         end else begin
            lock_on  <= 1'b0;
            lock_cnt <= '0;
         end
      end else if (lock_on && !lock_live) begin
         lock_on  <= 1'b0;
         lock_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cwr      <= 1'b0;
         crd      <= 1'b0;
         caddr_wr <= '0;
         caddr_rd <= '0;
         cdata_wr <= '0;
         csel     <= '0;
      end else begin
         cwr <= hs & g_we;
         crd <= hs & ~g_we;
         if (hs) begin
            csel <= g_sel;
            if (g_we) begin
               caddr_wr <= g_addr;
               cdata_wr <= g_wdata;
            end else begin
               caddr_rd <= g_addr;
            end
         end
      end
   end

   // Stage 1 lines up with cdata_rd from the memory; stage 2 covers the response cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_v      <= '0;
         tag_n      <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_data  <= '0;
      end else begin
         tag_v      <= {tag_v[1:0], hs & ~g_we};
         tag_n      <= {tag_n[1:0], gidx};
         rsp0_valid <= tag_v[1] & ~tag_n[1];
         rsp1_valid <= tag_v[1] & tag_n[1];
         if (tag_v[1] && !tag_n[1]) rsp0_data <= cdata_rd;
         if (tag_v[1] && tag_n[1])  rsp1_data <= cdata_rd;
      end
   end

   assign idle = ~hs & ~(|tag_v);

endmodule

// File: tb/tb_layer_mem_arbiter.sv
module tb_layer_mem_arbiter;
   localparam int AW = 12;
   localparam int DW = 20;
   localparam int MAX_LOCK = 4;
   localparam int NR = 600;

   logic clk = 1'b0;
   logic reset;
   logic req0_valid, req0_ready, req0_we, req0_lock, rsp0_valid;
   logic [2:0] req0_sel;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, rsp0_data;
   logic req1_valid, req1_ready, req1_we, req1_lock, rsp1_valid;
   logic [2:0] req1_sel;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, rsp1_data;
   logic cwr, crd, idle;
   logic [AW-1:0] caddr_wr, caddr_rd;
   logic [DW-1:0] cdata_wr, cdata_rd;
   logic [2:0] csel;

   always #5 clk = ~clk;

   layer_mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_sel(req0_sel),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_sel(req1_sel),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
      .cwr(cwr), .crd(crd), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr),
      .csel(csel), .cdata_rd(cdata_rd), .idle(idle)
   );

   // memory: registered read, data visible the cycle after crd
   logic [DW-1:0] mem [0:4095];
   logic mem_clr;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 4096; i++) mem[i] <= '0;
      end else if (cwr) begin
         mem[caddr_wr] <= cdata_wr;
      end
      if (crd) cdata_rd <= mem[caddr_rd];
   end

   int checks = 0;
   int errors = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req0_valid = 0; req0_we = 0; req0_sel = 0; req0_addr = 0; req0_wdata = 0; req0_lock = 0;
      req1_valid = 0; req1_we = 0; req1_sel = 0; req1_addr = 0; req1_wdata = 0; req1_lock = 0;
   endtask

   task automatic do_reset();
      clear_reqs();
      reset = 1; mem_clr = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0; mem_clr = 0;
   endtask

   task automatic drive(int n, logic we, logic [2:0] sel, logic [AW-1:0] a, logic [DW-1:0] d, logic lk);
      if (n == 0) begin
         req0_valid = 1; req0_we = we; req0_sel = sel; req0_addr = a; req0_wdata = d; req0_lock = lk;
      end else begin
         req1_valid = 1; req1_we = we; req1_sel = sel; req1_addr = a; req1_wdata = d; req1_lock = lk;
      end
   endtask

   task automatic chk_quiet(string nm);
      chk({nm, "_cwr"}, 32'(cwr), 0);
      chk({nm, "_crd"}, 32'(crd), 0);
      chk({nm, "_rsp0v"}, 32'(rsp0_valid), 0);
      chk({nm, "_rsp1v"}, 32'(rsp1_valid), 0);
      chk({nm, "_idle"}, 32'(idle), 1);
   endtask

   typedef struct {
      logic v0, v1, l0, l1;
      logic g0, g1, idl;
   } vec_t;
   vec_t tbl[19];

   function automatic vec_t mk(logic v0, logic v1, logic l0, logic l1, logic g0, logic g1);
      vec_t r;
      r.v0 = v0; r.v1 = v1; r.l0 = l0; r.l1 = l1; r.g0 = g0; r.g1 = g1;
      r.idl = !(v0 || v1);
      return r;
   endfunction

   typedef struct {
      logic vld, we, lock;
      logic [2:0] sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] d;
   } req_t;

   req_t p[2];
   logic [DW-1:0] mm [16];
   logic [1:0] exp_st [NR + 8];
   logic [AW-1:0] exp_a [NR + 8];
   logic [DW-1:0] exp_d [NR + 8];
   logic [2:0] exp_s [NR + 8];
   logic [1:0] exp_rsp [NR + 8];
   logic [DW-1:0] exp_rd [NR + 8];
   logic rd_hs [NR + 8];

   initial begin
      clear_reqs();
      reset = 1; mem_clr = 1;
      #1 req0_valid = 1;
      #3;
      // reset state, with a request pending
      chk("rst_ready0", 32'(req0_ready), 0);
      chk("rst_ready1", 32'(req1_ready), 0);
      chk("rst_caddr_wr", 32'(caddr_wr), 0);
      chk("rst_caddr_rd", 32'(caddr_rd), 0);
      chk("rst_cdata_wr", 32'(cdata_wr), 0);
      chk("rst_csel", 32'(csel), 0);
      chk("rst_rsp0d", 32'(rsp0_data), 0);
      chk("rst_rsp1d", 32'(rsp1_data), 0);
      chk_quiet("rst");
      do_reset();

      // simple write
      drive(0, 1, 3'd1, 12'h005, 20'h00ABC, 0);
      #4 chk("wr_ready0", 32'(req0_ready), 1);
      chk("wr_idle_busy", 32'(idle), 0);
      step(); clear_reqs();
      #4 chk("wr_cwr", 32'(cwr), 1);
      chk("wr_crd", 32'(crd), 0);
      chk("wr_caddr", 32'(caddr_wr), 32'h005);
      chk("wr_cdata", 32'(cdata_wr), 32'h00ABC);
      chk("wr_csel", 32'(csel), 1);
      chk("wr_idle", 32'(idle), 1);
      step();
      #4 chk("wr_csel_hold", 32'(csel), 1);
      chk("wr_cwr_drop", 32'(cwr), 0);

      // read back through requester 1
      step(); drive(0, 1, 3'd2, 12'h040, 20'h12345, 0);
      step(); clear_reqs();
      step(); drive(1, 0, 3'd1, 12'h040, 20'h0, 0);
      #4 chk("rd_ready1", 32'(req1_ready), 1);
      step(); clear_reqs();
      #4 chk("rd_crd", 32'(crd), 1);
      chk("rd_cwr", 32'(cwr), 0);
      chk("rd_caddr", 32'(caddr_rd), 32'h040);
      chk("rd_csel", 32'(csel), 1);
      step();
      #4 chk("rd_rsp1_early", 32'(rsp1_valid), 0);
      chk("rd_idle_t2", 32'(idle), 0);
      step();
      #4 chk("rd_rsp1v", 32'(rsp1_valid), 1);
      chk("rd_rsp1d", 32'(rsp1_data), 32'h12345);
      chk("rd_rsp0v", 32'(rsp0_valid), 0);
      step();
      #4 chk("rd_rsp1_pulse", 32'(rsp1_valid), 0);
      chk("rd_rsp1d_hold", 32'(rsp1_data), 32'h12345);
      chk("rd_idle_after", 32'(idle), 1);

      // read then write from the other requester
      step(); drive(1, 1, 3'd0, 12'h010, 20'h0BEEF, 0);
      step(); clear_reqs();
      step(); drive(0, 0, 3'd2, 12'h010, 20'h0, 0);
      step(); clear_reqs(); drive(1, 1, 3'd3, 12'h020, 20'h00777, 0);
      #4 chk("rw_ready1", 32'(req1_ready), 1);
      chk("rw_crd_t1", 32'(crd), 1);
      chk("rw_cwr_t1", 32'(cwr), 0);
      step(); clear_reqs();
      #4 chk("rw_cwr_t2", 32'(cwr), 1);
      chk("rw_crd_t2", 32'(crd), 0);
      chk("rw_caddr_wr", 32'(caddr_wr), 32'h020);
      chk("rw_csel", 32'(csel), 3);
      step();
      #4 chk("rw_rsp0v", 32'(rsp0_valid), 1);
      chk("rw_rsp0d", 32'(rsp0_data), 32'h0BEEF);
      chk("rw_rsp1v", 32'(rsp1_valid), 0);
      chk("rw_strobes", 32'({cwr, crd}), 0);

      // reset lands while a read is in flight
      step(); drive(0, 0, 3'd1, 12'h040, 20'h0, 0);
      step(); clear_reqs();
      #2 reset = 1;
      #1 chk("mr_crd", 32'(crd), 0);
      chk("mr_caddr_rd", 32'(caddr_rd), 0);
      chk("mr_csel", 32'(csel), 0);
      chk("mr_rsp0d", 32'(rsp0_data), 0);
      chk_quiet("mr_now");
      step(); reset = 0;
      for (int k = 0; k < 3; k++) begin
         #4 chk_quiet($sformatf("mr_after%0d", k));
         step();
      end

      // grant/lock rule table, writes only
      do_reset();
      tbl[0]  = mk(1, 1, 0, 1, 1, 0);
      tbl[1]  = mk(1, 1, 0, 1, 0, 1);
      tbl[2]  = mk(1, 1, 0, 1, 0, 1);
      tbl[3]  = mk(1, 1, 0, 1, 0, 1);
      tbl[4]  = mk(1, 1, 0, 1, 0, 1);
      tbl[5]  = mk(1, 1, 0, 1, 0, 1);
      tbl[6]  = mk(1, 1, 0, 0, 1, 0);
      tbl[7]  = mk(1, 1, 0, 0, 0, 1);
      tbl[8]  = mk(1, 1, 0, 0, 1, 0);
      tbl[9]  = mk(1, 1, 0, 1, 0, 1);
      tbl[10] = mk(1, 0, 0, 0, 1, 0);
      tbl[11] = mk(0, 1, 0, 0, 0, 1);
      tbl[12] = mk(1, 1, 1, 0, 1, 0);
      tbl[13] = mk(1, 1, 0, 0, 1, 0);
      tbl[14] = mk(1, 1, 0, 0, 0, 1);
      tbl[15] = mk(1, 0, 0, 0, 1, 0);
      tbl[16] = mk(0, 0, 0, 0, 0, 0);
      tbl[17] = mk(1, 1, 0, 0, 0, 1);
      tbl[18] = mk(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 19; i++) begin
         clear_reqs();
         if (tbl[i].v0) drive(0, 1, 3'd0, 12'(i), 20'(i), tbl[i].l0);
         if (tbl[i].v1) drive(1, 1, 3'd0, 12'(i + 32), 20'(i), tbl[i].l1);
         #4 chk($sformatf("tbl%0d_g0", i), 32'(req0_ready), 32'(tbl[i].g0));
         chk($sformatf("tbl%0d_g1", i), 32'(req1_ready), 32'(tbl[i].g1));
         chk($sformatf("tbl%0d_idle", i), 32'(idle), 32'(tbl[i].idl));
         step();
      end

      // randomized traffic against a transaction-level model
      do_reset();
      begin
         logic last_m, lk_on, held_sel_ok;
         int lk_who, lk_cnt, g, base;
         logic [2:0] hsel;
         logic [DW-1:0] hr0, hr1;
         logic exp_idle;
         last_m = 1; lk_on = 0; lk_who = 0; lk_cnt = 0;
         hsel = 0; hr0 = 0; hr1 = 0; held_sel_ok = 1;
         for (int i = 0; i < 16; i++) mm[i] = '0;
         for (int i = 0; i < NR + 8; i++) begin
            exp_st[i] = 0; exp_rsp[i] = 0; rd_hs[i] = 0;
            exp_a[i] = 0; exp_d[i] = 0; exp_s[i] = 0; exp_rd[i] = 0;
         end
         p[0].vld = 0; p[1].vld = 0;
         for (int c = 0; c < NR + 4; c++) begin
            for (int n = 0; n < 2; n++) begin
               if (!p[n].vld && c < NR && $urandom_range(0, 99) < 60) begin
                  p[n].vld  = 1;
                  p[n].we   = 1'($urandom_range(0, 1));
                  p[n].lock = ($urandom_range(0, 99) < 45);
                  p[n].sel  = 3'($urandom_range(0, 7));
                  p[n].addr = 12'h100 + 12'($urandom_range(0, 15));
                  p[n].d    = 20'($urandom);
               end
            end
            clear_reqs();
            for (int n = 0; n < 2; n++)
               if (p[n].vld) drive(n, p[n].we, p[n].sel, p[n].addr, p[n].d, p[n].lock);
            if (lk_on && !p[lk_who].vld) begin
               lk_on = 0; lk_cnt = 0;
            end
            g = -1;
            if (p[0].vld && p[1].vld) g = lk_on ? lk_who : (last_m ? 0 : 1);
            else if (p[0].vld) g = 0;
            else if (p[1].vld) g = 1;
            if (g >= 0) begin
               base = (lk_on && lk_who == g) ? lk_cnt : 0;
               if (p[g].lock && base < MAX_LOCK) begin
                  lk_on = 1; lk_who = g; lk_cnt = base + 1;
               end else begin
                  lk_on = 0; lk_cnt = 0;
               end
               last_m = 1'(g);
               exp_st[c + 1] = p[g].we ? 2'b10 : 2'b01;
               exp_a[c + 1] = p[g].addr;
               exp_d[c + 1] = p[g].d;
               exp_s[c + 1] = p[g].sel;
               if (p[g].we) begin
                  mm[p[g].addr[3:0]] = p[g].d;
               end else begin
                  rd_hs[c] = 1;
                  exp_rsp[c + 3] = (g == 0) ? 2'b01 : 2'b10;
                  exp_rd[c + 3] = mm[p[g].addr[3:0]];
               end
               p[g].vld = 0;
            end
            exp_idle = (g < 0) && !(c >= 1 && rd_hs[c - 1]) && !(c >= 2 && rd_hs[c - 2])
                       && !(c >= 3 && rd_hs[c - 3]);
            if (exp_st[c] != 0) hsel = exp_s[c];
            if (exp_rsp[c][0]) hr0 = exp_rd[c];
            if (exp_rsp[c][1]) hr1 = exp_rd[c];
            #4;
            chk($sformatf("rnd%0d_g", c), 32'({req1_ready, req0_ready}),
                32'((g == 1) ? 2'b10 : (g == 0) ? 2'b01 : 2'b00));
            chk($sformatf("rnd%0d_idle", c), 32'(idle), 32'(exp_idle));
            chk($sformatf("rnd%0d_strobe", c), 32'({cwr, crd}), 32'(exp_st[c]));
            if (exp_st[c] == 2'b10) begin
               chk($sformatf("rnd%0d_waddr", c), 32'(caddr_wr), 32'(exp_a[c]));
               chk($sformatf("rnd%0d_wdata", c), 32'(cdata_wr), 32'(exp_d[c]));
            end
            if (exp_st[c] == 2'b01)
               chk($sformatf("rnd%0d_raddr", c), 32'(caddr_rd), 32'(exp_a[c]));
            chk($sformatf("rnd%0d_csel", c), 32'(csel), 32'(hsel));
            chk($sformatf("rnd%0d_rspv", c), 32'({rsp1_valid, rsp0_valid}), 32'(exp_rsp[c]));
            chk($sformatf("rnd%0d_rsp0d", c), 32'(rsp0_data), 32'(hr0));
            chk($sformatf("rnd%0d_rsp1d", c), 32'(rsp1_data), 32'(hr1));
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
